// File: rtl/riscv_pkg.sv
// Shared register-file types for the write-back path: address width,
// register count and the {rd, data} entry carried through the aux queue.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // One-hot of a destination register; x0 never appears as a pending write.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] m;
        m     = '0;
        m[rd] = (rd != '0);
        return m;
    endfunction

endpackage

// File: rtl/writeback_fifo.sv
// Small synchronous FIFO of write-back entries. Besides the usual
// push/pop/full/empty/count it exports each slot's valid bit and rd so the
// top level can build the pending-write hazard mask.
module writeback_fifo
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push,
    input  wb_entry_t                             push_entry,
    input  logic                                  pop,
    output wb_entry_t                             head,
    output logic                                  full,
    output logic                                  empty,
    output logic [$clog2(FIFO_DEPTH):0]           count,
    output logic [FIFO_DEPTH-1:0]                 entry_valid,
    output logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Entry storage; slot validity is tracked separately so data needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy and per-slot valid bits; pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Per-slot destination export for the hazard mask.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            entry_rd[i] = mem[i].rd;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port driver. Merges the in-order pipeline result
// stream with a queued, backpressured aux stream (loads, mul/div) into a
// single registered write port, with an anti-starvation stall of the pipe
// and a pending-write mask for decode hazard checks.
module regfile_writeback
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    input  logic                  aux_valid,
    output logic                  aux_ready,
    input  logic [REG_ADDR_W-1:0] aux_rd,
    input  logic [XLEN-1:0]       aux_data,
    output logic                  pipe_stall,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [REG_ADDR_W-1:0] wrd,
    output logic [XLEN-1:0]       wbd,
    output logic                  wwreg
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SW    = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;

    wb_entry_t                             fifo_head;
    wb_entry_t                             fifo_in;
    logic                                  fifo_full;
    logic                                  fifo_empty;
    logic [CNT_W-1:0]                      fifo_count;
    logic [FIFO_DEPTH-1:0]                 fifo_valid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] fifo_rd;
    logic                                  fifo_push;
    logic                                  fifo_pop;
    logic                                  fifo_nonempty;
    logic                                  pipe_wins;
    logic                                  starve_hit;
    logic [SW-1:0]                         starve_cnt;

    // Full FIFO refuses aux even if a dequeue happens the same edge.
    assign aux_ready     = ~rst & (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_nonempty = ~fifo_empty;

    // x0 aux results are accepted by the handshake but never queued.
    assign fifo_in   = '{rd: aux_rd, data: aux_data};
    assign fifo_push = aux_valid & aux_ready & (aux_rd != '0) & ~fifo_full;

    // Pipe wins the port unless it is being held; a held pipe or an x0/idle
    // pipe leaves the port to the FIFO head.
    assign pipe_wins  = ~pipe_stall & pipe_valid & (pipe_rd != '0);
    assign fifo_pop   = fifo_nonempty & ~pipe_wins;
    assign starve_hit = pipe_wins & fifo_nonempty & (starve_cnt == SW'(STARVE_LIMIT - 1));

    writeback_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_entry  (fifo_in),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entry_valid (fifo_valid),
        .entry_rd    (fifo_rd)
    );

    // Count consecutive pipe pre-emptions of a waiting FIFO; hold the pipe one cycle at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else if (pipe_wins & fifo_nonempty) begin
            starve_cnt <= starve_hit ? '0 : starve_cnt + SW'(1);
            pipe_stall <= starve_hit;
        end else begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end
    end

    // Registered write port; address/data hold when no write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wwreg <= 1'b0;
            wrd   <= '0;
            wbd   <= '0;
        end else if (pipe_wins) begin
            wwreg <= 1'b1;
            wrd   <= pipe_rd;
            wbd   <= pipe_data;
        end else if (fifo_pop) begin
            wwreg <= 1'b1;
            wrd   <= fifo_head.rd;
            wbd   <= fifo_head.data;
        end else begin
            wwreg <= 1'b0;
        end
    end

    // Registers targeted by still-queued aux writes.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i]) begin
                pending_mask = pending_mask | rd_onehot(fifo_rd[i]);
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed stimulus through pipe/aux item
// queues, a queue-based reference model of the write port, a per-cycle
// compare process and hand-computed literal expectations.
module tb_regfile_writeback;
    import riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [63:0] pipe_data = '0;
    logic        aux_valid = 1'b0;
    logic [4:0]  aux_rd = '0;
    logic [63:0] aux_data = '0;
    logic        aux_ready;
    logic        pipe_stall;
    logic [31:0] pending_mask;
    logic [4:0]  wrd;
    logic [63:0] wbd;
    logic        wwreg;

    regfile_writeback #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_valid   (pipe_valid),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .aux_valid    (aux_valid),
        .aux_ready    (aux_ready),
        .aux_rd       (aux_rd),
        .aux_data     (aux_data),
        .pipe_stall   (pipe_stall),
        .pending_mask (pending_mask),
        .wrd          (wrd),
        .wbd          (wbd),
        .wwreg        (wwreg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    wb_entry_t   mq[$];
    int          m_starve = 0;
    bit          m_stall = 1'b0;
    bit          m_next_stall = 1'b0;
    bit          m_wwreg = 1'b0;
    logic [4:0]  m_wrd = '0;
    logic [63:0] m_wbd = '0;
    bit          pipe_took = 1'b0;
    bit          aux_took = 1'b0;
    bit          m_ne;
    bit          m_pw;
    wb_entry_t   m_head;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_starve  = 0;
            m_stall   = 1'b0;
            m_wwreg   = 1'b0;
            m_wrd     = '0;
            m_wbd     = '0;
            pipe_took = 1'b0;
            aux_took  = 1'b0;
        end else begin
            m_ne         = (mq.size() != 0);
            pipe_took    = pipe_valid && !m_stall;
            aux_took     = aux_valid && (mq.size() < DEPTH);
            m_pw         = pipe_took && (pipe_rd != 0);
            m_next_stall = 1'b0;
            if (m_pw) begin
                m_wwreg = 1'b1;
                m_wrd   = pipe_rd;
                m_wbd   = pipe_data;
                if (!m_ne) m_starve = 0;
                else if (m_starve == LIMIT - 1) begin
                    m_starve     = 0;
                    m_next_stall = 1'b1;
                end else m_starve++;
            end else if (m_ne) begin
                m_head   = mq.pop_front();
                m_wwreg  = 1'b1;
                m_wrd    = m_head.rd;
                m_wbd    = m_head.data;
                m_starve = 0;
            end else begin
                m_wwreg  = 1'b0;
                m_starve = 0;
            end
            if (aux_took && aux_rd != 0) mq.push_back('{rd: aux_rd, data: aux_data});
            m_stall = m_next_stall;
        end
    end

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("wwreg", 64'(wwreg), 64'(m_wwreg));
            chk("wrd", 64'(wrd), 64'(m_wrd));
            chk("wbd", wbd, m_wbd);
            chk("pipe_stall", 64'(pipe_stall), 64'(m_stall));
            chk("aux_ready", 64'(aux_ready), 64'(!rst && mq.size() < DEPTH));
            chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
        end
    end

    // ---------------- stimulus ----------------
    wb_entry_t pq[$];
    wb_entry_t aq[$];

    task automatic drive();
        pipe_valid = (pq.size() != 0);
        if (pipe_valid) begin
            pipe_rd   = pq[0].rd;
            pipe_data = pq[0].data;
        end
        aux_valid = (aq.size() != 0);
        if (aux_valid) begin
            aux_rd   = aq[0].rd;
            aux_data = aq[0].data;
        end
    endtask

    task automatic run(input int n);
        drive();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (pipe_took && pq.size() != 0) pq.delete(0);
            if (aux_took && aq.size() != 0) aq.delete(0);
            drive();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wwreg"}, 64'(wwreg), 64'd0);
        chk({tag, "_wrd"}, 64'(wrd), 64'd0);
        chk({tag, "_wbd"}, wbd, 64'd0);
        chk({tag, "_stall"}, 64'(pipe_stall), 64'd0);
        chk({tag, "_aux_ready"}, 64'(aux_ready), 64'd0);
        chk({tag, "_mask"}, 64'(pending_mask), 64'd0);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk_all_zero("rst0");
        rst = 1'b0;
        run(2);
        chk("idle_wwreg", 64'(wwreg), 64'd0);
        chk("idle_aux_ready", 64'(aux_ready), 64'd1);

        // Pipe only
        pq.push_back('{rd: 5'd5, data: 64'hDEAD_BEEF});
        run(1);
        chk("pipe_wwreg", 64'(wwreg), 64'd1);
        chk("pipe_wrd", 64'(wrd), 64'd5);
        chk("pipe_wbd", wbd, 64'hDEAD_BEEF);
        pq.push_back('{rd: 5'd0, data: 64'h123});
        run(1);
        chk("pipe_x0_wwreg", 64'(wwreg), 64'd0);
        chk("pipe_x0_wrd_hold", 64'(wrd), 64'd5);
        run(1);

        // Aux only, four back-to-back
        for (int i = 1; i <= 4; i++) aq.push_back('{rd: 5'(i), data: 64'h100 + 64'(i)});
        run(1);
        chk("aux_first_mask", 64'(pending_mask), 64'h2);
        chk("aux_first_wwreg", 64'(wwreg), 64'd0);
        run(1);
        chk("aux_x1_wrd", 64'(wrd), 64'd1);
        chk("aux_x1_wbd", wbd, 64'h101);
        run(3);
        chk("aux_x4_wrd", 64'(wrd), 64'd4);
        chk("aux_x4_wbd", wbd, 64'h104);
        chk("aux_drained_mask", 64'(pending_mask), 64'h0);
        run(1);
        chk("aux_idle_wwreg", 64'(wwreg), 64'd0);

        // Full FIFO under a busy pipe, then starvation stall
        for (int k = 0; k < 20; k++) pq.push_back('{rd: 5'(10 + k), data: 64'hA000 + 64'(k)});
        for (int i = 1; i <= 5; i++) aq.push_back('{rd: 5'(i), data: 64'hB000 + 64'(i)});
        run(4);
        chk("full_aux_ready", 64'(aux_ready), 64'd0);
        chk("full_mask", 64'(pending_mask), 64'h1E);
        chk("full_aux_held", 64'(aux_valid), 64'd1);
        run(4);
        chk("pre_starve_stall", 64'(pipe_stall), 64'd0);
        run(1);
        chk("starve_stall", 64'(pipe_stall), 64'd1);
        chk("starve_last_pipe_wrd", 64'(wrd), 64'd18);
        run(1);
        chk("stall_head_wrd", 64'(wrd), 64'd1);
        chk("stall_head_wbd", wbd, 64'hB001);
        chk("stall_cleared", 64'(pipe_stall), 64'd0);
        chk("stall_aux_ready", 64'(aux_ready), 64'd1);
        run(1);
        chk("held_pipe_wrd", 64'(wrd), 64'd19);
        chk("held_pipe_wbd", wbd, 64'hA009);
        pq.delete();
        run(8);
        chk("drain_wrd", 64'(wrd), 64'd5);
        chk("drain_wbd", wbd, 64'hB005);
        chk("drain_mask", 64'(pending_mask), 64'h0);

        // x0 aux filtering
        chk("x0_aux_ready", 64'(aux_ready), 64'd1);
        aq.push_back('{rd: 5'd0, data: 64'hFFFF});
        run(1);
        chk("x0_mask", 64'(pending_mask), 64'h0);
        chk("x0_accepted", 64'(aq.size()), 64'd0);
        run(2);
        chk("x0_no_write", 64'(wwreg), 64'd0);

        // Async reset with three queued entries
        for (int k = 0; k < 6; k++) pq.push_back('{rd: 5'(20 + k), data: 64'hC000 + 64'(k)});
        for (int i = 6; i <= 8; i++) aq.push_back('{rd: 5'(i), data: 64'hD000 + 64'(i)});
        run(3);
        chk("prerst_mask", 64'(pending_mask), 64'h1C0);
        chk("prerst_wrd", 64'(wrd), 64'd22);
        #2;
        rst = 1'b1;
        pq.delete();
        aq.delete();
        drive();
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(3);
        chk("post_rst_wwreg", 64'(wwreg), 64'd0);
        chk("post_rst_mask", 64'(pending_mask), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
